axis_rx_hub: RTL and testbench
==============================

// Module: axis_rx_hub
// PURPOSE
//  Memory-mapped receive hub for CHANNELS independent AXI-Stream sources (PS/2 keyboard, UART bridges, ...).
//  Each channel buffers its stream in its own FIFO. The CPU reads, flushes and monitors each FIFO through per-channel registers.
//  One combined, maskable interrupt output.
//  Sits beside the standard peripherals on the CPU data bus; the top-level read mux and its byte swap are unchanged.
//  Successor to the single-channel unbuffered AXIS CPU interface.
// PARAMETERS
//  CHANNELS      2              number of AXIS slave channels, 1..4
//  DATA_WIDTH    8              tdata width per channel, 1..32
//  FIFO_DEPTH    8              entries per channel; power of 2, 2..64
//  DROP_ON_FULL  1              1: tready held high, bytes arriving while full are discarded and the overflow flag is set; 0: tready = !full (backpressure)
//  BASE_ADDR     32'hE4000000   window base; decode compares addr_i[31:8]
// PORTS
//  axis_aclk_i     in   1                    single clock, CPU clock domain
//  axis_aresetn_i  in   1                    reset, synchronous, active-low
//  addr_i          in   32                   CPU address
//  data_i          in   32                   CPU write data (register order)
//  data_w_i        in   1                    write strobe for the current access
//  data_o          out  32                   read data, registered
//  data_access_o   out  1                    combinational: addr_i inside window
//  irq_o           out  1                    level interrupt, registered
//  s_axis_tvalid_i in   CHANNELS             per-channel tvalid
//  s_axis_tready_o out  CHANNELS             per-channel tready
//  s_axis_tdata_i  in   CHANNELS*DATA_WIDTH  channel c = bits [c*DATA_WIDTH +: DATA_WIDTH]
// BEHAVIOUR
//  Reset (axis_aresetn_i=0 at a clock edge):
//   - all FIFOs empty; overflow flags and irq enables cleared.
//   - data_o=0, irq_o=0.
//   - s_axis_tready_o=0 during reset; after release, all 1s.
//   - reset mid-transfer discards all buffered data.
//  Register map per channel c at BASE_ADDR + c*0x10; offsets outside the map read 0 and ignore writes:
//   +0x0 DATA   R: pop head, value zero-extended. Writes ignored.
//   +0x4 STATUS R: [0]=empty [1]=full [2]=overflow [15:8]=level (0..FIFO_DEPTH). Write 1 to bit 2 clears overflow.
//   +0x8 CTRL   RW: [0]=irq_rx_en [1]=irq_ovf_en. Write 1 to [2] flushes (self-clearing, reads 0).
//  Read latency: data_o is valid the cycle after addr_i is presented. Cycles without a read give data_o=0.
//  Pop:
//   - one pop per access, on the first cycle addr_i hits DATA with data_w_i=0.
//   - an access spanning several cycles is detected through a registered hit flag and pops once.
//   - a new pop needs the address to leave DATA for at least one cycle.
//   - read of an empty FIFO: data_o=0, no pointer change, no error flag.
//  Push: handshake tvalid&tready at a rising edge writes tdata at the tail.
//   - DROP_ON_FULL=0: tready = !full, from registered state; no same-cycle pop-to-push bypass.
//   - DROP_ON_FULL=1: tvalid while full discards the byte and sets overflow (sticky until W1C or reset).
//  Simultaneous push+pop on a non-full, non-empty FIFO: level unchanged, both take effect.
//  Flush takes priority over a same-cycle push or pop: the FIFO is empty on the next cycle and the incoming byte is lost.
//  W1C of overflow in the same cycle as a new overflow event: the flag stays set.
//  Pointers are log2(FIFO_DEPTH)+1 bits; wrap-around is natural modulo; full = MSBs differ and LSBs equal.
//  irq_o is registered (one cycle after the cause) and is the OR over channels c of:
//   (irq_rx_en[c] & !empty[c]) | (irq_ovf_en[c] & overflow[c]).
//  No combinational path from s_axis_tvalid_i to s_axis_tready_o.
// STRUCTURE
//  Shared package axis_hub_pkg:
//   - register offset constants (DATA=0, STATUS=4, CTRL=8).
//   - channel stride 0x10.
//   - STATUS/CTRL bit position constants.
//  Sub-module axis_sync_fifo (WIDTH, DEPTH): push/pop/flush inputs; dout, empty, full, level outputs; inferred distributed RAM.
//  Top: address decode, pop-edge logic, CTRL/overflow registers, read mux, irq reduction.
// TESTING
//  1 Single byte: push 8'h1C on ch0 -> STATUS reads empty=0 level=1. Read DATA -> 32'h0000001C, then STATUS empty=1.
//  2 Fill ch1 with 8 bytes 0x01..0x08 in both modes:
//    - DROP_ON_FULL=0: tready=0 once full; hold 8'h09 valid, pop once -> 0x01; 8'h09 accepted next cycle, order preserved.
//    - DROP_ON_FULL=1: a 9th byte 8'hAA sets overflow; 8 reads give 0x01..0x08; 8'hAA is never seen.
//  3 Read held on DATA for 4 cycles with 3 bytes queued -> exactly one pop, level 3->2.
//  4 IRQ path:
//    - irq_rx_en=1 on ch0, push 0x55 -> irq_o=1 within 2 cycles; pop -> irq_o=0.
//    - overflow with irq_ovf_en=1 -> irq_o=1 until the W1C of STATUS bit 2.
//  5 Flush with push in the same cycle: 5 bytes queued, CTRL write 0x4 coinciding with tvalid on 0x77 -> level=0 next cycle, 0x77 discarded.
//  6 Reset mid-stream: pulse axis_aresetn_i low for 1 cycle with 4 bytes queued -> data_o=0, irq_o=0, all STATUS empty=1; wrap test: 3*FIFO_DEPTH push/pop pairs keep order.

Source files
------------

// File: rtl/axis_hub_pkg.sv
// Shared constants for the AXI-Stream receive hub: register offsets,
// channel stride and STATUS/CTRL bit positions.
package axis_hub_pkg;

    typedef enum logic [3:0] {
        REG_DATA   = 4'h0,
        REG_STATUS = 4'h4,
        REG_CTRL   = 4'h8
    } reg_off_e;

    localparam int unsigned CH_STRIDE = 16;
    localparam int unsigned CH_SHIFT  = 4;

    localparam int unsigned STAT_EMPTY_BIT = 0;
    localparam int unsigned STAT_FULL_BIT  = 1;
    localparam int unsigned STAT_OVF_BIT   = 2;
    localparam int unsigned STAT_LEVEL_LSB = 8;

    localparam int unsigned CTRL_RX_EN_BIT  = 0;
    localparam int unsigned CTRL_OVF_EN_BIT = 1;
    localparam int unsigned CTRL_FLUSH_BIT  = 2;

endpackage

// File: rtl/axis_sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers; flush overrides push/pop.
module axis_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_din,
    input  logic                     i_pop,
    input  logic                     i_flush,
    output logic [WIDTH-1:0]         o_dout,
    output logic                     o_empty,
    output logic                     o_full,
    output logic [$clog2(DEPTH):0]   o_level
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_wptr == r_rptr);
    assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign o_level   = r_wptr - r_rptr;
    assign o_dout    = r_mem[r_rptr[AW-1:0]];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_flush) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + {{AW{1'b0}}, 1'b1};
            if (w_do_pop)  r_rptr <= r_rptr + {{AW{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_din;
    end

endmodule

// File: rtl/axis_rx_hub.sv
// Memory-mapped multi-channel AXI-Stream receive hub: per-channel FIFOs,
// DATA/STATUS/CTRL registers and one combined maskable interrupt.
module axis_rx_hub
    import axis_hub_pkg::*;
#(
    parameter int unsigned CHANNELS     = 2,
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned FIFO_DEPTH   = 8,
    parameter int unsigned DROP_ON_FULL = 1,
    parameter logic [31:0] BASE_ADDR    = 32'hE4000000
) (
    input  logic                           axis_aclk_i,
    input  logic                           axis_aresetn_i,
    input  logic [31:0]                    addr_i,
    input  logic [31:0]                    data_i,
    input  logic                           data_w_i,
    output logic [31:0]                    data_o,
    output logic                           data_access_o,
    output logic                           irq_o,
    input  logic [CHANNELS-1:0]            s_axis_tvalid_i,
    output logic [CHANNELS-1:0]            s_axis_tready_o,
    input  logic [CHANNELS*DATA_WIDTH-1:0] s_axis_tdata_i
);
    localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;

    logic                  w_in_window;
    logic [3:0]            w_off;
    logic [31:0]           w_rdata;
    logic [CHANNELS-1:0]   w_sel, w_data_hit, w_pop, w_push, w_flush;
    logic [CHANNELS-1:0]   w_ctrl_wr, w_ovf_clr, w_ovf_set, w_empty, w_full;
    logic [DATA_WIDTH-1:0] w_dout  [CHANNELS];
    logic [LW-1:0]         w_level [CHANNELS];
    logic [CHANNELS-1:0]   r_hit, r_ovf, r_rx_en, r_ovf_en;
    logic                  r_ready_en;
    logic                  w_unused;

    assign w_in_window   = (addr_i[31:8] == BASE_ADDR[31:8]);
    assign w_off         = addr_i[3:0];
    assign data_access_o = w_in_window;
    assign w_unused      = ^data_i[31:3];

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        assign w_sel[c]      = w_in_window && (addr_i[7:CH_SHIFT] == 4'(c));
        assign w_data_hit[c] = w_sel[c] && (w_off == 4'(REG_DATA));
        // r_hit tracks the address alone, so a held access pops only on its first cycle
        assign w_pop[c]      = w_data_hit[c] && !data_w_i && !r_hit[c];
        assign w_ctrl_wr[c]  = w_sel[c] && (w_off == 4'(REG_CTRL)) && data_w_i;
        assign w_flush[c]    = w_ctrl_wr[c] && data_i[CTRL_FLUSH_BIT];
        assign w_ovf_clr[c]  = w_sel[c] && (w_off == 4'(REG_STATUS)) && data_w_i
                               && data_i[STAT_OVF_BIT];
        assign w_ovf_set[c]  = (DROP_ON_FULL != 0) && r_ready_en && s_axis_tvalid_i[c] && w_full[c];
        assign w_push[c]     = s_axis_tvalid_i[c] && s_axis_tready_o[c] && !w_full[c];
        assign s_axis_tready_o[c] = r_ready_en && ((DROP_ON_FULL != 0) || !w_full[c]);

        axis_sync_fifo #(
            .WIDTH (DATA_WIDTH),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .i_clk   (axis_aclk_i),
            .i_rst_n (axis_aresetn_i),
            .i_push  (w_push[c]),
            .i_din   (s_axis_tdata_i[c*DATA_WIDTH +: DATA_WIDTH]),
            .i_pop   (w_pop[c]),
            .i_flush (w_flush[c]),
            .o_dout  (w_dout[c]),
            .o_empty (w_empty[c]),
            .o_full  (w_full[c]),
            .o_level (w_level[c])
        );
    end

    always_comb begin
        w_rdata = '0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            if (w_sel[c] && !data_w_i) begin
                case (w_off)
                    4'(REG_DATA): begin
                        if (r_hit[c])        w_rdata = data_o;
                        else if (!w_empty[c]) w_rdata = 32'(w_dout[c]);
                    end
                    4'(REG_STATUS): begin
                        w_rdata[STAT_EMPTY_BIT]       = w_empty[c];
                        w_rdata[STAT_FULL_BIT]        = w_full[c];
                        w_rdata[STAT_OVF_BIT]         = r_ovf[c];
                        w_rdata[STAT_LEVEL_LSB +: 8]  = 8'(w_level[c]);
                    end
                    4'(REG_CTRL): begin
                        w_rdata[CTRL_RX_EN_BIT]  = r_rx_en[c];
                        w_rdata[CTRL_OVF_EN_BIT] = r_ovf_en[c];
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge axis_aclk_i) begin
        if (!axis_aresetn_i) begin
            r_hit      <= '0;
            r_ovf      <= '0;
            r_rx_en    <= '0;
            r_ovf_en   <= '0;
            r_ready_en <= 1'b0;
            data_o     <= '0;
            irq_o      <= 1'b0;
        end else begin
            r_ready_en <= 1'b1;
            r_hit      <= w_data_hit;
            data_o     <= w_rdata;
            irq_o      <= |((r_rx_en & ~w_empty) | (r_ovf_en & r_ovf));
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                if (w_ctrl_wr[c]) begin
                    r_rx_en[c]  <= data_i[CTRL_RX_EN_BIT];
                    r_ovf_en[c] <= data_i[CTRL_OVF_EN_BIT];
                end
                if (w_ovf_set[c])      r_ovf[c] <= 1'b1;
                else if (w_ovf_clr[c]) r_ovf[c] <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axis_rx_hub.sv
// Bench for axis_rx_hub: a drop-on-full instance and a backpressure instance
// share the CPU bus, checked against queue-based per-channel models.
module tb_axis_rx_hub;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        wen = 1'b0;
    logic [31:0] rdata [2];
    logic        acc [2];
    logic        irq [2];
    logic [1:0]  tvalid [2];
    logic [1:0]  tready [2];
    logic [15:0] tdata [2];
    logic [31:0] base [2];

    logic [7:0]  mq [4][$];
    bit          ovf [4];
    bit          rxen [4];
    bit          ovfen [4];
    int          n_checks = 0;
    int          n_pass = 0;

    always #5 clk = ~clk;

    axis_rx_hub #(.CHANNELS(2), .DATA_WIDTH(8), .FIFO_DEPTH(DEPTH), .DROP_ON_FULL(1),
                  .BASE_ADDR(32'hE4000000)) u_drop (
        .axis_aclk_i(clk), .axis_aresetn_i(rstn), .addr_i(addr), .data_i(wdata),
        .data_w_i(wen), .data_o(rdata[0]), .data_access_o(acc[0]), .irq_o(irq[0]),
        .s_axis_tvalid_i(tvalid[0]), .s_axis_tready_o(tready[0]), .s_axis_tdata_i(tdata[0]));

    axis_rx_hub #(.CHANNELS(2), .DATA_WIDTH(8), .FIFO_DEPTH(DEPTH), .DROP_ON_FULL(0),
                  .BASE_ADDR(32'hE4001000)) u_bp (
        .axis_aclk_i(clk), .axis_aresetn_i(rstn), .addr_i(addr), .data_i(wdata),
        .data_w_i(wen), .data_o(rdata[1]), .data_access_o(acc[1]), .irq_o(irq[1]),
        .s_axis_tvalid_i(tvalid[1]), .s_axis_tready_o(tready[1]), .s_axis_tdata_i(tdata[1]));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] stat(input int k);
        logic [31:0] s = '0;
        s[0]    = (mq[k].size() == 0);
        s[1]    = (mq[k].size() == DEPTH);
        s[2]    = ovf[k];
        s[15:8] = 8'(mq[k].size());
        return s;
    endfunction

    function automatic logic exp_irq(input int d);
        logic r = 1'b0;
        for (int c = 0; c < 2; c++)
            r |= (rxen[d*2+c] && mq[d*2+c].size() != 0) || (ovfen[d*2+c] && ovf[d*2+c]);
        return r;
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < 4; k++) begin
            mq[k].delete();
            ovf[k] = 0; rxen[k] = 0; ovfen[k] = 0;
        end
    endfunction

    // One-cycle push attempt; drop instance (d=0) discards when full and flags overflow.
    task automatic push(input int d, input int ch, input logic [7:0] b);
        int k = d*2 + ch;
        bit rdy = (d == 0) ? 1'b1 : (mq[k].size() < DEPTH);
        chk("tready", 32'(tready[d][ch]), 32'(rdy));
        tvalid[d][ch] = 1'b1;
        tdata[d][ch*8 +: 8] = b;
        tick();
        tvalid[d][ch] = 1'b0;
        if (mq[k].size() < DEPTH) mq[k].push_back(b);
        else if (d == 0) ovf[k] = 1;
    endtask

    task automatic rd(input int d, input int ch, input int off, input string tag);
        logic [31:0] e = '0;
        int k = d*2 + ch;
        addr = base[d] + 32'(ch*16 + off);
        wen = 1'b0;
        #1 chk({tag, "/access"}, 32'(acc[d]), 32'd1);
        if (ch < 2) begin
            case (off)
                0: if (mq[k].size() != 0) e = 32'(mq[k].pop_front());
                4: e = stat(k);
                8: e = {30'b0, ovfen[k], rxen[k]};
                default: e = '0;
            endcase
        end
        tick();
        chk(tag, rdata[d], e);
        addr = '0;
        tvalid[0] = '0; tvalid[1] = '0;
        tick();
    endtask

    task automatic wr(input int d, input int ch, input int off, input logic [31:0] v);
        int k = d*2 + ch;
        addr = base[d] + 32'(ch*16 + off);
        wdata = v;
        wen = 1'b1;
        if (off == 4 && v[2]) ovf[k] = 0;
        if (off == 8) begin
            rxen[k] = v[0]; ovfen[k] = v[1];
            if (v[2]) mq[k].delete();
        end
        tick();
        addr = '0; wen = 1'b0; wdata = '0;
        tvalid[0] = '0; tvalid[1] = '0;
        tick();
    endtask

    initial begin
        logic [7:0] b;
        base[0] = 32'hE4000000;
        base[1] = 32'hE4001000;
        tvalid[0] = '0; tvalid[1] = '0; tdata[0] = '0; tdata[1] = '0;
        model_reset();

        tick(); tick();
        chk("rst_data", rdata[0], 32'h0);
        chk("rst_irq", 32'(irq[0]), 32'h0);
        chk("rst_tready_drop", 32'(tready[0]), 32'h0);
        chk("rst_tready_bp", 32'(tready[1]), 32'h0);
        rstn = 1'b1;
        tick();
        chk("rel_tready_drop", 32'(tready[0]), 32'h3);
        chk("rel_tready_bp", 32'(tready[1]), 32'h3);

        // Single byte
        push(0, 0, 8'h1C);
        rd(0, 0, 4, "t1_status");
        rd(0, 0, 0, "t1_data");
        rd(0, 0, 4, "t1_status_empty");
        rd(0, 0, 0, "t1_empty_read");
        rd(0, 0, 12, "unmapped_off");
        rd(0, 2, 4, "unmapped_ch");

        // Fill in drop mode; 0xAA must be discarded
        for (int i = 1; i <= 8; i++) push(0, 1, 8'(i));
        push(0, 1, 8'hAA);
        rd(0, 1, 4, "t2d_status_full");
        for (int i = 0; i < 8; i++) rd(0, 1, 0, "t2d_data");
        rd(0, 1, 4, "t2d_status_after");

        // Fill in backpressure mode; held 0x09 accepted only after a pop
        for (int i = 1; i <= 8; i++) push(1, 1, 8'(i));
        chk("t2b_tready_full", 32'(tready[1][1]), 32'h0);
        tvalid[1][1] = 1'b1;
        tdata[1][15:8] = 8'h09;
        tick();
        chk("t2b_tready_held", 32'(tready[1][1]), 32'h0);
        addr = base[1] + 32'h10;
        tick();
        chk("t2b_pop", rdata[1], 32'(mq[3].pop_front()));
        chk("t2b_tready_after_pop", 32'(tready[1][1]), 32'h1);
        addr = '0;
        tick();
        tvalid[1][1] = 1'b0;
        mq[3].push_back(8'h09);
        rd(1, 1, 4, "t2b_status");
        for (int i = 0; i < 8; i++) rd(1, 1, 0, "t2b_data");

        // Same-cycle W1C and overflow: overflow wins
        wr(0, 1, 4, 32'h4);
        for (int i = 0; i < 8; i++) push(0, 1, 8'($urandom));
        tvalid[0][1] = 1'b1;
        wr(0, 1, 4, 32'h4);
        ovf[1] = 1;
        rd(0, 1, 4, "w1c_vs_ovf");
        wr(0, 1, 8, 32'h4);
        wr(0, 1, 4, 32'h4);

        // Held read pops once
        for (int i = 0; i < 3; i++) push(0, 0, 8'($urandom));
        addr = base[0];
        tick();
        chk("t3_first", rdata[0], 32'(mq[0].pop_front()));
        tick(); tick(); tick();
        addr = '0;
        tick();
        rd(0, 0, 4, "t3_level");
        rd(0, 0, 0, "t3_drain");
        rd(0, 0, 0, "t3_drain");

        // IRQ paths
        wr(0, 0, 8, 32'h1);
        chk("t4_irq_idle", 32'(irq[0]), 32'(exp_irq(0)));
        rd(0, 0, 8, "t4_ctrl");
        push(0, 0, 8'h55);
        tick();
        chk("t4_irq_rx", 32'(irq[0]), 32'(exp_irq(0)));
        rd(0, 0, 0, "t4_data");
        chk("t4_irq_pop", 32'(irq[0]), 32'(exp_irq(0)));
        wr(0, 0, 8, 32'h2);
        for (int i = 0; i < DEPTH + 1; i++) push(0, 0, 8'($urandom));
        tick();
        chk("t4_irq_ovf", 32'(irq[0]), 32'(exp_irq(0)));
        wr(0, 0, 4, 32'h4);
        chk("t4_irq_w1c", 32'(irq[0]), 32'(exp_irq(0)));
        rd(0, 0, 4, "t4_status");
        wr(0, 0, 8, 32'h4);

        // Flush beats a same-cycle push
        for (int i = 0; i < 5; i++) push(0, 0, 8'($urandom));
        tvalid[0][0] = 1'b1;
        tdata[0][7:0] = 8'h77;
        wr(0, 0, 8, 32'h4);
        rd(0, 0, 4, "t5_flushed");
        rd(0, 0, 8, "t5_ctrl_selfclear");

        // Reset mid-stream
        for (int i = 0; i < 4; i++) push(0, 0, 8'($urandom));
        wr(0, 0, 8, 32'h1);
        chk("t6_irq_before", 32'(irq[0]), 32'(exp_irq(0)));
        addr = base[0] + 32'h4;
        rstn = 1'b0;
        tick();
        chk("t6_data", rdata[0], 32'h0);
        chk("t6_irq", 32'(irq[0]), 32'h0);
        chk("t6_tready", 32'(tready[0]), 32'h0);
        addr = '0;
        rstn = 1'b1;
        tick();
        model_reset();
        chk("t6_tready_rel", 32'(tready[0]), 32'h3);
        for (int d = 0; d < 2; d++)
            for (int c = 0; c < 2; c++) rd(d, c, 4, "t6_status");

        // Pointer wrap-around
        for (int i = 0; i < 3*DEPTH; i++) begin
            push(0, 0, 8'($urandom));
            rd(0, 0, 0, "wrap_data");
        end
        rd(0, 0, 4, "wrap_status");

        // Random mixed traffic
        for (int i = 0; i < 300; i++) begin
            int d = int'($urandom_range(1, 0));
            int c = int'($urandom_range(1, 0));
            case ($urandom_range(5, 0))
                0, 1: begin b = 8'($urandom); push(d, c, b); end
                2:    rd(d, c, 0, "rnd_data");
                3:    rd(d, c, 4, "rnd_status");
                4:    wr(d, c, 4, 32'h4);
                default: begin
                    wr(d, c, 8, 32'($urandom_range(3, 0)));
                    chk("rnd_irq", 32'(irq[d]), 32'(exp_irq(d)));
                end
            endcase
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
